// File: rtl/brick_game_pkg.sv
// Shared screen geometry, widths and game-state encoding for the brick game.
// Also holds the serve placement and miss test used by the sequencer.
package brick_game_pkg;

    localparam int unsigned H          = 640;
    localparam int unsigned V          = 480;
    localparam int unsigned BALL_W     = 16;
    localparam int unsigned BALL_H     = 10;
    localparam int unsigned BOARD_Y    = 467;
    localparam int unsigned SERVE_Y    = 455;
    localparam int unsigned MISS_Y     = 530;
    localparam int unsigned BRICK_W    = 32;
    localparam int unsigned BRICK_H    = 20;
    localparam int unsigned BRICK_BITS = 3;
    localparam int unsigned SERVE_DX   = 40;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COORD_W1 = COORD_W + 1;
    localparam int unsigned DIR_W    = 2;
    localparam int unsigned LIVES_W  = 2;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned BRICK_N  = (H / BRICK_W) * (V / BRICK_H) * BRICK_BITS;

    typedef enum logic [STATE_W-1:0] {
        SERVE = 3'd0,
        PLAY  = 3'd1,
        LOST  = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    // Ball resting on the paddle, offset to its middle.
    function automatic logic [COORD_W-1:0] serve_x(input logic [COORD_W-1:0] board_x);
        return board_x + COORD_W'(SERVE_DX);
    endfunction

    // Falling ball whose next bottom edge passes the miss line (11-bit sum, may wrap).
    function automatic logic is_miss(input logic down,
                                     input logic [COORD_W-1:0] y,
                                     input logic [COORD_W-1:0] vy);
        logic [COORD_W1-1:0] bottom;
        bottom = {1'b0, y} + {1'b0, vy} + COORD_W1'(BALL_H);
        return down && (bottom > COORD_W1'(MISS_Y));
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running game tick: one-cycle pulse every TICK_DIV clocks.
module tick_divider #(
    parameter int unsigned TICK_DIV = 1666667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ball_game_sequencer.sv
// Game-level sequencer: owns ball/brick state and commits ball_control results once per tick.
// Handles serve, play, life loss, win and game over.
module ball_game_sequencer
    import brick_game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1666667,
    parameter int unsigned LIVES0     = 3,
    parameter int unsigned VX0        = 4,
    parameter int unsigned VY0        = 4,
    parameter int unsigned LOST_TICKS = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch,
    input  logic [COORD_W-1:0]   board_x,
    input  logic [BRICK_N-1:0]   init_bricks,
    input  logic [BRICK_N-1:0]   nx_bricks,
    input  logic [COORD_W-1:0]   nx_ball_x,
    input  logic [COORD_W-1:0]   nx_ball_y,
    input  logic [COORD_W-1:0]   nx_ball_vx,
    input  logic [COORD_W-1:0]   nx_ball_vy,
    input  logic [DIR_W-1:0]     nx_ball_dir,
    input  logic                 collision_trig,
    output logic [BRICK_N-1:0]   bricks,
    output logic [COORD_W-1:0]   ball_x,
    output logic [COORD_W-1:0]   ball_y,
    output logic [COORD_W-1:0]   ball_vx,
    output logic [COORD_W-1:0]   ball_vy,
    output logic [DIR_W-1:0]     ball_dir,
    output logic [LIVES_W-1:0]   lives,
    output logic [SCORE_W-1:0]   score,
    output logic [STATE_W-1:0]   state,
    output logic                 tick,
    output logic                 hit
);
    localparam int unsigned LOST_W = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;

    game_state_t       st;
    logic              launch_q;
    logic              launch_pend;
    logic              launch_edge;
    logic              consume;
    logic              miss;
    logic [LOST_W-1:0] lost_cnt;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign state       = st;
    assign launch_edge = launch & ~launch_q;
    assign miss        = is_miss(ball_dir[0], ball_y, ball_vy);
    // A pending launch is used up only by the transitions that wait for it.
    assign consume     = tick & launch_pend & ((st == SERVE) || (st == WIN) || (st == OVER));

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= SERVE;
            bricks      <= init_bricks;
            ball_x      <= serve_x(board_x);
            ball_y      <= COORD_W'(SERVE_Y);
            ball_vx     <= COORD_W'(VX0);
            ball_vy     <= COORD_W'(VY0);
            ball_dir    <= 2'b10;
            lives       <= LIVES_W'(LIVES0);
            score       <= '0;
            hit         <= 1'b0;
            launch_q    <= 1'b0;
            launch_pend <= 1'b0;
            lost_cnt    <= '0;
        end else begin
            launch_q    <= launch;
            launch_pend <= (st == LOST) ? 1'b0 : ((launch_pend & ~consume) | launch_edge);
            hit         <= 1'b0;
            if (tick) begin
                case (st)
                    SERVE: begin
                        ball_x   <= serve_x(board_x);
                        ball_y   <= COORD_W'(SERVE_Y);
                        ball_dir <= 2'b10;
                        ball_vx  <= COORD_W'(VX0);
                        ball_vy  <= COORD_W'(VY0);
                        if (launch_pend) st <= PLAY;
                    end
                    PLAY: begin
                        if (miss) begin
                            lives    <= lives - LIVES_W'(1);
                            ball_x   <= serve_x(board_x);
                            ball_y   <= COORD_W'(SERVE_Y);
                            ball_dir <= 2'b10;
                            ball_vx  <= COORD_W'(VX0);
                            ball_vy  <= COORD_W'(VY0);
                            lost_cnt <= '0;
                            st       <= (lives == LIVES_W'(1)) ? OVER : LOST;
                        end else begin
                            bricks   <= nx_bricks;
                            ball_x   <= nx_ball_x;
                            ball_y   <= nx_ball_y;
                            ball_vx  <= nx_ball_vx;
                            ball_vy  <= nx_ball_vy;
                            ball_dir <= nx_ball_dir;
                            hit      <= collision_trig;
                            if (nx_bricks != bricks) begin
                                score <= (score == '1) ? score : score + SCORE_W'(1);
                            end
                            if (nx_bricks == '0) st <= WIN;
                        end
                    end
                    LOST: begin
                        lost_cnt <= lost_cnt + LOST_W'(1);
                        ball_x   <= serve_x(board_x);
                        ball_y   <= COORD_W'(SERVE_Y);
                        ball_dir <= 2'b10;
                        ball_vx  <= COORD_W'(VX0);
                        ball_vy  <= COORD_W'(VY0);
                        if (lost_cnt == LOST_W'(LOST_TICKS - 1)) st <= SERVE;
                    end
                    WIN: begin
                        if (launch_pend) begin
                            bricks <= init_bricks;
                            st     <= SERVE;
                        end
                    end
                    OVER: begin
                        if (launch_pend) begin
                            bricks <= init_bricks;
                            score  <= '0;
                            lives  <= LIVES_W'(LIVES0);
                            st     <= SERVE;
                        end
                    end
                    default: st <= SERVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_game_sequencer.sv
// Randomized and directed bench for ball_game_sequencer against a tick-level game model.
module tb_ball_game_sequencer;

    localparam int TD = 4;
    localparam int NB = 1440;

    logic            clk = 1'b0;
    logic            rst;
    logic            launch;
    logic [9:0]      board_x;
    logic [NB-1:0]   init_bricks;
    logic [NB-1:0]   nx_bricks;
    logic [9:0]      nx_ball_x, nx_ball_y, nx_ball_vx, nx_ball_vy;
    logic [1:0]      nx_ball_dir;
    logic            collision_trig;
    logic [NB-1:0]   bricks;
    logic [9:0]      ball_x, ball_y, ball_vx, ball_vy;
    logic [1:0]      ball_dir;
    logic [1:0]      lives;
    logic [15:0]     score;
    logic [2:0]      state;
    logic            tick;
    logic            hit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ball_game_sequencer #(
        .TICK_DIV(TD), .LIVES0(3), .VX0(4), .VY0(4), .LOST_TICKS(60)
    ) dut (
        .clk(clk), .rst(rst), .launch(launch), .board_x(board_x),
        .init_bricks(init_bricks), .nx_bricks(nx_bricks),
        .nx_ball_x(nx_ball_x), .nx_ball_y(nx_ball_y),
        .nx_ball_vx(nx_ball_vx), .nx_ball_vy(nx_ball_vy),
        .nx_ball_dir(nx_ball_dir), .collision_trig(collision_trig),
        .bricks(bricks), .ball_x(ball_x), .ball_y(ball_y),
        .ball_vx(ball_vx), .ball_vy(ball_vy), .ball_dir(ball_dir),
        .lives(lives), .score(score), .state(state), .tick(tick), .hit(hit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        int first;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            first = -1;
            for (int i = 0; i < NB; i++) if (first < 0 && act[i] !== exp[i]) first = i;
            $display("FAIL %s: got ones=%0d expected ones=%0d, first diff bit %0d (t=%0t)",
                     name, $countones(act), $countones(exp), first, $time);
        end
    endtask

    // Game model: one step of the rules per clock, in plain integers.
    bit          m_valid = 0;
    int          m_cyc, m_state, m_x, m_y, m_vx, m_vy, m_lives, m_score, m_lost;
    bit [1:0]    m_dir;
    bit [NB-1:0] m_bricks;
    bit          m_hit, m_pend, m_lq;

    function automatic int serve_pos(input logic [9:0] bx);
        return (int'(bx) + 40) % 1024;
    endfunction

    always @(posedge clk) begin
        bit tk, old_pend, edge_seen, used;
        int old_state;
        if (rst) begin
            m_valid = 1; m_cyc = 0; m_state = 0; m_bricks = init_bricks;
            m_x = serve_pos(board_x); m_y = 455; m_vx = 4; m_vy = 4; m_dir = 2'b10;
            m_lives = 3; m_score = 0; m_hit = 0; m_pend = 0; m_lq = 0; m_lost = 0;
        end else if (m_valid) begin
            tk = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            old_pend = m_pend; old_state = m_state;
            edge_seen = launch && !m_lq;
            m_lq = launch;
            used = 0;
            m_hit = 0;
            if (tk) begin
                if (old_state == 0) begin
                    m_x = serve_pos(board_x); m_y = 455; m_vx = 4; m_vy = 4; m_dir = 2'b10;
                    if (old_pend) begin m_state = 1; used = 1; end
                end else if (old_state == 1) begin
                    if (m_dir[0] && ((m_y + m_vy + 10) % 2048) > 530) begin
                        m_state = (m_lives == 1) ? 4 : 2;
                        m_lives = m_lives - 1;
                        m_x = serve_pos(board_x); m_y = 455; m_vx = 4; m_vy = 4; m_dir = 2'b10;
                        m_lost = 0;
                    end else begin
                        if (nx_bricks != m_bricks && m_score < 65535) m_score++;
                        if (nx_bricks == '0) m_state = 3;
                        m_bricks = nx_bricks;
                        m_x = nx_ball_x; m_y = nx_ball_y; m_vx = nx_ball_vx; m_vy = nx_ball_vy;
                        m_dir = nx_ball_dir;
                        m_hit = collision_trig;
                    end
                end else if (old_state == 2) begin
                    if (m_lost == 59) m_state = 0;
                    m_lost++;
                    m_x = serve_pos(board_x); m_y = 455; m_vx = 4; m_vy = 4; m_dir = 2'b10;
                end else if (old_state == 3) begin
                    if (old_pend) begin m_bricks = init_bricks; m_state = 0; used = 1; end
                end else begin
                    if (old_pend) begin
                        m_bricks = init_bricks; m_score = 0; m_lives = 3; m_state = 0; used = 1;
                    end
                end
            end
            m_pend = (old_state == 2) ? 1'b0 : ((old_pend && !used) || edge_seen);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", 32'(state), 32'(m_state));
            chkb("bricks", bricks, m_bricks);
            chk("ball_x", 32'(ball_x), 32'(m_x));
            chk("ball_y", 32'(ball_y), 32'(m_y));
            chk("ball_vx", 32'(ball_vx), 32'(m_vx));
            chk("ball_vy", 32'(ball_vy), 32'(m_vy));
            chk("ball_dir", 32'(ball_dir), 32'(m_dir));
            chk("lives", 32'(lives), 32'(m_lives));
            chk("score", 32'(score), 32'(m_score));
            chk("tick", 32'(tick), 32'((m_cyc % TD) == TD - 1));
            chk("hit", 32'(hit), 32'(m_hit));
        end
    end

    // Advance through the next tick edge; leaves us at the negedge after it.
    task automatic tick_step();
        int n = 0;
        while (tick !== 1'b1 && n < 2 * TD) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
        @(negedge clk);
    endtask

    task automatic launch_pulse();
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
    endtask

    task automatic set_ball(input int x, input int y, input int vx, input int vy, input logic [1:0] d);
        nx_ball_x = 10'(x); nx_ball_y = 10'(y); nx_ball_vx = 10'(vx); nx_ball_vy = 10'(vy);
        nx_ball_dir = d;
    endtask

    // Serve, commit a ball about to miss, then miss with the given nx_bricks.
    task automatic lose_life(input logic [NB-1:0] miss_bricks);
        launch_pulse();
        tick_step();
        set_ball(300, 515, 4, 6, 2'b01);
        nx_bricks = m_bricks;
        tick_step();
        nx_bricks = miss_bricks;
        tick_step();
    endtask

    logic [NB-1:0] pat, q, r, tmp;
    int first;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; launch = 1'b0; board_x = 10'd100; collision_trig = 1'b0;
        for (int i = 0; i < NB / 32; i++) pat[i*32 +: 32] = $urandom;
        pat[0] = 1'b1;
        init_bricks = pat; nx_bricks = pat;
        set_ball(0, 0, 0, 0, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ball_x", 32'(ball_x), 32'd140);
        chk("rst_ball_y", 32'(ball_y), 32'd455);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chkb("rst_bricks", bricks, pat);

        first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            @(negedge clk);
            if (tick) first = i;
        end
        chk("first_tick", 32'(first), 32'd3);
        @(negedge clk);

        launch_pulse();
        tick_step();
        chk("launch_play", 32'(state), 32'd1);

        q = pat; q[5] = ~q[5];
        set_ball(300, 200, 5, 3, 2'b10);
        nx_bricks = q; collision_trig = 1'b1;
        @(negedge clk);
        chkb("offtick_bricks", bricks, pat);
        chk("offtick_score", 32'(score), 32'd0);
        chk("offtick_hit", 32'(hit), 32'd0);
        tick_step();
        chkb("commit_bricks", bricks, q);
        chk("commit_score", 32'(score), 32'd1);
        chk("commit_hit", 32'(hit), 32'd1);
        chk("commit_y", 32'(ball_y), 32'd200);
        @(negedge clk);
        chk("hit_one_cycle", 32'(hit), 32'd0);

        set_ball(300, 515, 4, 6, 2'b01);
        tick_step();
        chk("pre_miss_y", 32'(ball_y), 32'd515);
        r = q; r[9] = ~r[9];
        nx_bricks = r;
        tick_step();
        chk("miss_lives", 32'(lives), 32'd2);
        chk("miss_state", 32'(state), 32'd2);
        chk("miss_x", 32'(ball_x), 32'd140);
        chk("miss_y", 32'(ball_y), 32'd455);
        chkb("miss_bricks", bricks, q);
        chk("miss_score", 32'(score), 32'd1);
        chk("miss_hit", 32'(hit), 32'd0);
        collision_trig = 1'b0;
        repeat (59) tick_step();
        chk("lost_hold", 32'(state), 32'd2);
        tick_step();
        chk("lost_done", 32'(state), 32'd0);

        lose_life(m_bricks);
        chk("second_miss_lives", 32'(lives), 32'd1);
        repeat (60) tick_step();
        chk("second_lost_done", 32'(state), 32'd0);
        tmp = '0;
        lose_life(tmp);
        chk("over_state", 32'(state), 32'd4);
        chk("over_lives", 32'(lives), 32'd0);
        chkb("over_bricks", bricks, q);

        launch_pulse();
        tick_step();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_state", 32'(state), 32'd0);
        chkb("restart_bricks", bricks, pat);

        launch_pulse();
        tick_step();
        set_ball(300, 200, 4, 4, 2'b10);
        nx_bricks = '0;
        tick_step();
        chk("win_state", 32'(state), 32'd3);
        chk("win_score", 32'(score), 32'd1);
        launch = 1'b1;
        tick_step();
        chk("win_reload_state", 32'(state), 32'd0);
        chkb("win_reload_bricks", bricks, pat);
        chk("win_keep_score", 32'(score), 32'd1);
        repeat (9) tick_step();
        chk("held_launch_once", 32'(state), 32'd0);
        launch = 1'b0;
        @(negedge clk);

        launch_pulse();
        tick_step();
        chk("pre_rst_play", 32'(state), 32'd1);
        board_x = 10'd200;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_x", 32'(ball_x), 32'd240);
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_lives", 32'(lives), 32'd3);
        chk("mid_rst_dir", 32'(ball_dir), 32'd2);

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(7, 0) == 0) launch = ~launch;
            if ($urandom_range(15, 0) == 0) board_x = 10'($urandom_range(600, 0));
            if ($urandom_range(199, 0) == 0) begin
                for (int i = 0; i < NB / 32; i++) tmp[i*32 +: 32] = $urandom;
                init_bricks = tmp;
            end
            set_ball($urandom_range(1023, 0),
                     ($urandom_range(9, 0) < 7) ? $urandom_range(500, 0) : $urandom_range(600, 500),
                     $urandom_range(15, 0), $urandom_range(15, 0), 2'($urandom_range(3, 0)));
            collision_trig = 1'($urandom_range(1, 0));
            tmp = m_bricks;
            case ($urandom_range(99, 0)) inside
                [0:59]:  nx_bricks = tmp;
                [60:96]: begin tmp[$urandom_range(NB - 1, 0)] = 1'b0; nx_bricks = tmp; end
                default: nx_bricks = '0;
            endcase
            rst = ($urandom_range(999, 0) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
